// File: rtl/galvo_scan.sv
// galvo_scan
//   Raster-scan position generator and dual-channel galvo DAC SPI driver.
//   Each accepted galvo_go steps the horizontal position (wrapping into a line
//   advance and, at the last line, a frame wrap). The new H position is then
//   written to the DAC, followed by the V position when the line advanced.
//   scan_restart returns the scan to the origin and writes both channels.
//
// Ports
//   clk_adc, rst_adc_n         : clock, asynchronous active-low reset
//   galvo_go                   : one-cycle step request (ignored when scan_en=0)
//   scan_en                    : enables acceptance of galvo_go
//   scan_restart               : one-cycle restart to origin, highest priority
//   h_pixels, v_lines          : scan limits (count minus 1)
//   galvoh, galvov             : current scan position
//   galvo_spi_done             : pulse when an update sequence finishes
//   frame_done                 : pulse when the vertical position wraps
//   busy, overrun              : sequence in progress / sticky dropped request
//   spi_cs_n, spi_sclk, spi_mosi : DAC SPI (mode 0, MSB first, 16-bit words)
module galvo_scan #(
  parameter int SCLK_DIV = 2,
  parameter int POS_W    = 11
) (
  input  logic             clk_adc,
  input  logic             rst_adc_n,
  input  logic             galvo_go,
  input  logic             scan_en,
  input  logic             scan_restart,
  input  logic [POS_W-1:0] h_pixels,
  input  logic [POS_W-1:0] v_lines,
  output logic [POS_W-1:0] galvoh,
  output logic [POS_W-1:0] galvov,
  output logic             galvo_spi_done,
  output logic             frame_done,
  output logic             busy,
  output logic             overrun,
  output logic             spi_cs_n,
  output logic             spi_sclk,
  output logic             spi_mosi
);

  typedef enum logic [2:0] {
    S_IDLE, S_UPDATE, S_CS_SETUP, S_SHIFT, S_CS_HOLD, S_GAP, S_DONE
  } state_t;

  localparam logic [3:0] DIV_M1 = 4'(SCLK_DIV - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;       // cycles within the current timed phase
  logic [3:0]       bit_q, bit_d;       // bit index in the word, 0 = MSB
  logic             phase_q, phase_d;   // SHIFT: 0 = sclk low half, 1 = high half
  logic             ch_q, ch_d;         // channel of the word in flight
  logic             h_owed_q, h_owed_d;
  logic             v_owed_q, v_owed_d;
  logic             pend_q, pend_d;
  logic             ovr_q, ovr_d;
  logic             init_q, init_d;     // limits still to be loaded after reset
  logic [POS_W-1:0] lim_h_q, lim_h_d;
  logic [POS_W-1:0] lim_v_q, lim_v_d;
  logic [POS_W-1:0] pos_h_q, pos_h_d;
  logic [POS_W-1:0] pos_v_q, pos_v_d;
  logic             frame_q, frame_d;
  logic             cs_n_q, cs_n_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             go_acc;
  logic             cnt_end;
  logic             line_adv;
  logic [15:0]      word_d;

  assign go_acc   = galvo_go && scan_en && !scan_restart;
  assign cnt_end  = (cnt_q == DIV_M1);
  assign line_adv = (pos_h_q == lim_h_q);

  // State and datapath registers
  always_ff @(posedge clk_adc or negedge rst_adc_n) begin
    if (!rst_adc_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      phase_q  <= 1'b0;
      ch_q     <= 1'b0;
      h_owed_q <= 1'b0;
      v_owed_q <= 1'b0;
      pend_q   <= 1'b0;
      ovr_q    <= 1'b0;
      init_q   <= 1'b1;
      lim_h_q  <= '0;
      lim_v_q  <= '0;
      pos_h_q  <= '0;
      pos_v_q  <= '0;
      frame_q  <= 1'b0;
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      phase_q  <= phase_d;
      ch_q     <= ch_d;
      h_owed_q <= h_owed_d;
      v_owed_q <= v_owed_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
      init_q   <= init_d;
      lim_h_q  <= lim_h_d;
      lim_v_q  <= lim_v_d;
      pos_h_q  <= pos_h_d;
      pos_v_q  <= pos_v_d;
      frame_q  <= frame_d;
      cs_n_q   <= cs_n_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    phase_d  = phase_q;
    ch_d     = ch_q;
    h_owed_d = h_owed_q;
    v_owed_d = v_owed_q;
    pend_d   = pend_q;
    ovr_d    = ovr_q;
    init_d   = 1'b0;
    lim_h_d  = lim_h_q;
    lim_v_d  = lim_v_q;
    pos_h_d  = pos_h_q;
    pos_v_d  = pos_v_q;
    frame_d  = 1'b0;

    if (init_q) begin
      lim_h_d = h_pixels;
      lim_v_d = v_lines;
    end

    // Requests arriving mid-sequence queue one deep; DONE handles its own.
    if (go_acc && state_q != S_IDLE && state_q != S_DONE) begin
      if (pend_q) ovr_d  = 1'b1;
      else        pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (go_acc) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        if (line_adv) begin
          pos_h_d = '0;
          if (pos_v_q == lim_v_q) begin
            pos_v_d = '0;
            frame_d = 1'b1;
          end else begin
            pos_v_d = pos_v_q + 1'b1;
          end
        end else begin
          pos_h_d = pos_h_q + 1'b1;
        end
        state_d  = S_CS_SETUP;
        cnt_d    = '0;
        bit_d    = '0;
        phase_d  = 1'b0;
        ch_d     = 1'b0;
        h_owed_d = 1'b0;
        v_owed_d = line_adv;
      end
      S_CS_SETUP: begin
        if (cnt_end) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          phase_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_SHIFT: begin
        if (cnt_end) begin
          cnt_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (bit_q == 4'd15) state_d = S_CS_HOLD;
            else                bit_d   = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_CS_HOLD: begin
        if (cnt_end) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_GAP: begin
        if (cnt_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          phase_d = 1'b0;
          if (h_owed_q) begin
            state_d  = S_CS_SETUP;
            ch_d     = 1'b0;
            h_owed_d = 1'b0;
          end else if (v_owed_q) begin
            state_d  = S_CS_SETUP;
            ch_d     = 1'b1;
            v_owed_d = 1'b0;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        // The pending slot frees this cycle, so a new go simply refills it.
        if (pend_q) begin
          state_d = S_UPDATE;
          pend_d  = go_acc;
        end else if (go_acc) begin
          state_d = S_UPDATE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Restart overrides everything: abort, home, then write both channels
    // after one GAP period.
    if (scan_restart) begin
      state_d  = S_GAP;
      cnt_d    = '0;
      bit_d    = '0;
      phase_d  = 1'b0;
      ch_d     = 1'b0;
      h_owed_d = 1'b1;
      v_owed_d = 1'b1;
      pend_d   = 1'b0;
      ovr_d    = 1'b0;
      lim_h_d  = h_pixels;
      lim_v_d  = v_lines;
      pos_h_d  = '0;
      pos_v_d  = '0;
      frame_d  = 1'b0;
    end
  end

  // Output logic, decoded from next state so every output leaves a flop
  always_comb begin
    word_d = {2'b00, ch_d, 2'b00, (ch_d ? pos_v_d : pos_h_d)};
    cs_n_d = !(state_d inside {S_CS_SETUP, S_SHIFT, S_CS_HOLD});
    sclk_d = (state_d == S_SHIFT) && phase_d;
    mosi_d = cs_n_d ? 1'b0 : word_d[4'd15 - bit_d];
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  assign galvoh         = pos_h_q;
  assign galvov         = pos_v_q;
  assign galvo_spi_done = done_q;
  assign frame_done     = frame_q;
  assign busy           = busy_q;
  assign overrun        = ovr_q;
  assign spi_cs_n       = cs_n_q;
  assign spi_sclk       = sclk_q;
  assign spi_mosi       = mosi_q;

endmodule

// File: tb/tb_galvo_scan.sv
// tb_galvo_scan
//   Scoreboard bench for galvo_scan (SCLK_DIV=2). Stimulus pushes the expected
//   position/latency of each update sequence and the expected DAC words;
//   monitors pop and compare on galvo_spi_done and on each completed SPI word.
module tb_galvo_scan;

  logic        clk_adc = 1'b0;
  logic        rst_adc_n;
  logic        galvo_go;
  logic        scan_en;
  logic        scan_restart;
  logic [10:0] h_pixels;
  logic [10:0] v_lines;
  logic [10:0] galvoh;
  logic [10:0] galvov;
  logic        galvo_spi_done;
  logic        frame_done;
  logic        busy;
  logic        overrun;
  logic        spi_cs_n;
  logic        spi_sclk;
  logic        spi_mosi;

  galvo_scan #(.SCLK_DIV(2), .POS_W(11)) dut (
    .clk_adc(clk_adc), .rst_adc_n(rst_adc_n), .galvo_go(galvo_go),
    .scan_en(scan_en), .scan_restart(scan_restart), .h_pixels(h_pixels),
    .v_lines(v_lines), .galvoh(galvoh), .galvov(galvov),
    .galvo_spi_done(galvo_spi_done), .frame_done(frame_done), .busy(busy),
    .overrun(overrun), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi)
  );

  always #5 clk_adc = ~clk_adc;

  typedef struct {
    logic [10:0] h;
    logic [10:0] v;
    int          t0;
    int          lat;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] wq[$];
  int          cyc = 0;
  int          nchecks = 0;
  int          nerrs = 0;
  int          frames = 0;
  logic        act_en = 1'b0;
  logic        act_seen = 1'b0;

  always @(posedge clk_adc) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    nchecks++;
    if (act !== req) begin
      nerrs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Sequence monitor
  always @(negedge clk_adc) begin
    if (rst_adc_n && galvo_spi_done) begin
      if (sbq.size() == 0) begin
        chk("done_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("done_h", 32'(galvoh), 32'(e.h));
        chk("done_v", 32'(galvov), 32'(e.v));
        chk("done_latency", 32'(cyc - e.t0), 32'(e.lat));
      end
    end
  end

  // Frame monitor: the pulse must coincide with the wrapped position
  always @(negedge clk_adc) begin
    if (rst_adc_n && frame_done) begin
      frames++;
      chk("frame_pos_v", 32'(galvov), 32'd0);
    end
  end

  // SPI monitor: bits captured on sclk rising, words compared at cs_n rising
  logic        prev_sclk = 1'b0;
  logic        prev_cs = 1'b1;
  logic [15:0] shreg = '0;
  int          nbits = 0;
  int          cs_low = 0;
  always @(negedge clk_adc) begin
    if (!spi_cs_n) cs_low++;
    if (spi_sclk && !prev_sclk && !spi_cs_n) begin
      shreg = {shreg[14:0], spi_mosi};
      nbits++;
    end
    if (spi_cs_n && !prev_cs) begin
      if (nbits == 16) begin
        if (wq.size() == 0) begin
          chk("word_unexpected", 32'(shreg), 32'hFFFF_FFFF);
        end else begin
          chk("spi_word", 32'(shreg), 32'(wq.pop_front()));
        end
        chk("cs_low_cycles", 32'(cs_low), 32'd68);
      end
      nbits  = 0;
      cs_low = 0;
    end
    if (act_en && (busy || !spi_cs_n || spi_sclk)) act_seen = 1'b1;
    prev_sclk = spi_sclk;
    prev_cs   = spi_cs_n;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_adc);
  endtask

  task automatic pulse_go();
    galvo_go = 1'b1;
    @(negedge clk_adc);
    galvo_go = 1'b0;
  endtask

  task automatic push_seq(input logic [10:0] h, input logic [10:0] v, input int t0, input int lat);
    exp_t e;
    e.h = h; e.v = v; e.t0 = t0; e.lat = lat;
    sbq.push_back(e);
  endtask

  task automatic restart_exp(input logic [10:0] hp, input logic [10:0] vl);
    h_pixels = hp;
    v_lines  = vl;
    push_seq(11'd0, 11'd0, cyc, 143);
    wq.push_back(16'h0000);
    wq.push_back(16'h2000);
    scan_restart = 1'b1;
    @(negedge clk_adc);
    scan_restart = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || wq.size() != 0) && n < 3000) begin
      @(negedge clk_adc);
      n++;
    end
    chk("drain_timeout", 32'(sbq.size() + wq.size()), 32'd0);
    wait_cyc(3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [10:0] h_tab[4] = '{11'd1, 11'd2, 11'd3, 11'd0};
  logic [10:0] v_tab[4] = '{11'd0, 11'd0, 11'd0, 11'd1};
  int          l_tab[4] = '{72, 72, 72, 142};
  logic [10:0] fv_tab[3] = '{11'd1, 11'd2, 11'd0};

  initial begin
    int t;
    int f0;
    rst_adc_n    = 1'b0;
    galvo_go     = 1'b0;
    scan_en      = 1'b1;
    scan_restart = 1'b0;
    h_pixels     = 11'd3;
    v_lines      = 11'd1;
    wait_cyc(4);
    chk("rst_galvoh", 32'(galvoh), 32'd0);
    chk("rst_galvov", 32'(galvov), 32'd0);
    chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
    chk("rst_sclk", 32'(spi_sclk), 32'd0);
    chk("rst_mosi", 32'(spi_mosi), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_done", 32'(galvo_spi_done), 32'd0);
    rst_adc_n = 1'b1;
    wait_cyc(4);

    // Four steps with limH=3, limV=1
    for (int i = 0; i < 4; i++) begin
      push_seq(h_tab[i], v_tab[i], cyc, l_tab[i]);
      wq.push_back({5'b00000, h_tab[i]});
      if (v_tab[i] != 11'd0) wq.push_back({5'b00100, v_tab[i]});
      pulse_go();
      if (i == 0) chk("busy_cycle1", 32'(busy), 32'd1);
      wait_cyc(199);
    end
    drain();
    chk("step4_galvoh", 32'(galvoh), 32'd0);
    chk("step4_galvov", 32'(galvov), 32'd1);
    chk("no_frame_yet", 32'(frames), 32'd0);

    // Restart from idle reloads limH=7, limV=3
    restart_exp(11'd7, 11'd3);
    chk("restart_idle_h", 32'(galvoh), 32'd0);
    chk("restart_idle_v", 32'(galvov), 32'd0);
    drain();

    // Two requests 10 cycles apart: second served right after first
    t = cyc;
    push_seq(11'd1, 11'd0, t, 72);      wq.push_back(16'h0001);
    pulse_go(); wait_cyc(9);
    push_seq(11'd2, 11'd0, t + 10, 134); wq.push_back(16'h0002);
    pulse_go();
    drain();
    chk("pending_no_overrun", 32'(overrun), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Third request while pending is dropped and sets overrun
    t = cyc;
    push_seq(11'd3, 11'd0, t, 72);      wq.push_back(16'h0003);
    pulse_go(); wait_cyc(9);
    push_seq(11'd4, 11'd0, t + 10, 134); wq.push_back(16'h0004);
    pulse_go(); wait_cyc(9);
    pulse_go();
    chk("overrun_set", 32'(overrun), 32'd1);
    drain();
    chk("dropped_go_h", 32'(galvoh), 32'd4);

    // Step to H=5 and capture the word
    push_seq(11'd5, 11'd0, cyc, 72);    wq.push_back(16'h0005);
    pulse_go();
    drain();
    chk("overrun_sticky", 32'(overrun), 32'd1);

    // Restart in the middle of SHIFT
    pulse_go();
    wait_cyc(29);
    chk("mid_shift_cs", 32'(spi_cs_n), 32'd0);
    restart_exp(11'd7, 11'd3);
    chk("abort_cs_n", 32'(spi_cs_n), 32'd1);
    chk("abort_sclk", 32'(spi_sclk), 32'd0);
    chk("abort_h", 32'(galvoh), 32'd0);
    chk("abort_v", 32'(galvov), 32'd0);
    chk("abort_overrun", 32'(overrun), 32'd0);
    drain();

    // limH=0, limV=2: every step advances the line
    restart_exp(11'd0, 11'd2);
    drain();
    f0 = frames;
    for (int i = 0; i < 3; i++) begin
      push_seq(11'd0, fv_tab[i], cyc, 142);
      wq.push_back(16'h0000);
      wq.push_back({5'b00100, fv_tab[i]});
      pulse_go();
      drain();
      chk("frame_count", 32'(frames - f0), (i == 2) ? 32'd1 : 32'd0);
    end

    // scan_en low: requests ignored
    scan_en  = 1'b0;
    act_seen = 1'b0;
    act_en   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pulse_go();
      wait_cyc(20);
    end
    wait_cyc(60);
    act_en = 1'b0;
    chk("scan_dis_activity", 32'(act_seen), 32'd0);
    chk("scan_dis_h", 32'(galvoh), 32'd0);
    chk("scan_dis_v", 32'(galvov), 32'd0);

    // Asynchronous reset in the middle of a word
    scan_en = 1'b1;
    pulse_go();
    wait_cyc(20);
    chk("pre_reset_cs", 32'(spi_cs_n), 32'd0);
    #2 rst_adc_n = 1'b0;
    #1;
    chk("async_rst_cs_n", 32'(spi_cs_n), 32'd1);
    chk("async_rst_sclk", 32'(spi_sclk), 32'd0);
    chk("async_rst_v", 32'(galvov), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    @(negedge clk_adc);
    rst_adc_n = 1'b1;
    wait_cyc(10);

    chk("final_seq_queue", 32'(sbq.size()), 32'd0);
    chk("final_word_queue", 32'(wq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule

// File: doc/galvo_scan.md
# galvo_scan

Raster-scan position generator and galvo DAC SPI driver in the `clk_adc` domain. It consumes the `galvo_go` pixel strobes from the master controller and advances the horizontal and vertical scan position. It writes each new position to the dual-channel galvo DAC over SPI. It returns `galvoh`, `galvov` and the `galvo_spi_done` pulse to the master controller for status read-back and pixel timing.

## Interface
Parameters:
- `SCLK_DIV`, default 2: SCLK half-period in `clk_adc` cycles; legal range 1–15.
- `POS_W`, default 11: position width; fixed to match the master controller's `galvoh`/`galvov`.

Ports:
- `clk_adc`, in, 1: ADC sample clock, the only clock.
- `rst_adc_n`, in, 1: asynchronous active-low reset.
- `galvo_go`, in, 1: one-cycle step request.
- `scan_en`, in, 1: when low, `galvo_go` is ignored.
- `scan_restart`, in, 1: one-cycle pulse; return to origin and write both channels.
- `h_pixels`, in, 11: pixels per line, minus 1; sampled at reset release and on `scan_restart`.
- `v_lines`, in, 11: lines per frame, minus 1; sampled with `h_pixels`.
- `galvoh`, out, 11: current horizontal position.
- `galvov`, out, 11: current vertical position.
- `galvo_spi_done`, out, 1: one-cycle pulse when an update sequence completes.
- `frame_done`, out, 1: one-cycle pulse when the vertical position wraps.
- `busy`, out, 1: high from request acceptance until `galvo_spi_done`.
- `overrun`, out, 1: sticky; cleared only by reset or `scan_restart`.
- `spi_cs_n`, out, 1: DAC chip select.
- `spi_sclk`, out, 1: DAC serial clock.
- `spi_mosi`, out, 1: DAC serial data.

## Operation
- Reset values: `galvoh`=0, `galvov`=0, `spi_cs_n`=1, `spi_sclk`=0, `spi_mosi`=0, `busy`=0, `overrun`=0. All pulse outputs are 0. Internal limits are 0; one cycle after release the limits load from `h_pixels`/`v_lines`.
- Step (accepted `galvo_go` with `scan_en`=1):
  - If `galvoh`==limH: `galvoh`←0 and the line advances.
  - Otherwise `galvoh`←`galvoh`+1.
  - Line advance: if `galvov`==limV, `galvov`←0 and `frame_done` pulses; otherwise `galvov`+1.
- Position registers update in the UPDATE cycle. They are visible on `galvoh`/`galvov` the cycle after.
- DAC word: 16 bits, MSB first, = {2'b00, ch, 2'b00, pos[10:0]}, where ch=0 is H and ch=1 is V.
- Each sequence writes the H word, then the V word only if the line advanced or the sequence came from `scan_restart`.
- State machine:
  - IDLE → UPDATE on request.
  - UPDATE → CS_SETUP.
  - CS_SETUP (SCLK_DIV cycles, cs_n=0, mosi=bit15) → SHIFT.
  - SHIFT: 16 bits. Each bit is SCLK_DIV cycles sclk=0 then SCLK_DIV cycles sclk=1. mosi changes only at the start of the low phase; the DAC samples on the rising edge.
  - SHIFT → CS_HOLD (SCLK_DIV cycles, sclk=0, cs_n=0) → GAP (SCLK_DIV cycles, cs_n=1).
  - GAP → CS_SETUP if the V word is still owed.
  - GAP → DONE otherwise.
  - DONE: one cycle, `galvo_spi_done`=1 → IDLE, or → UPDATE if a request is pending.
- Pending: one-deep flag.
  - An accepted `galvo_go` while `busy` sets pending.
  - An accepted `galvo_go` while pending is already set sets `overrun` and is dropped.
- `scan_restart`: highest priority, from any state.
  - Aborts the SPI transfer: cs_n→1 and sclk→0 the next cycle.
  - Clears pending and `overrun`, and reloads the limits.
  - Sets position to 0,0 and starts a two-word sequence after one GAP period.
- `galvo_go` coincident with `scan_restart` is discarded.
- `scan_en` falling mid-sequence does not abort the sequence. It does stop pending from being set.

## Timing
- One word = 35·SCLK_DIV cycles: CS_SETUP SCLK_DIV + SHIFT 32·SCLK_DIV + CS_HOLD SCLK_DIV + GAP SCLK_DIV.
- H-only sequence: `galvo_go` at cycle 0 → `busy`=1 at cycle 1 → `galvo_spi_done` at cycle 2+35·SCLK_DIV.
- H+V sequence: `galvo_spi_done` at cycle 2+70·SCLK_DIV.
- A pending request enters UPDATE the cycle after DONE.
- The `frame_done` pulse occurs in the cycle after UPDATE, coincident with the new position.
- All outputs are registered; none are combinational from inputs.

## Test plan
- Reset, then limH=3, limV=1, SCLK_DIV=2, four `galvo_go` 200 cycles apart:
  - `galvoh` steps 1,2,3,0; `galvov`=1 after the 4th step.
  - The first three `galvo_spi_done` come 72 cycles after go; the 4th comes 142 cycles after.
- SPI capture on sclk rising after go with `galvoh`→5: bits 0x0005. Line-advance word with V=1: 0x2001. cs_n is low for exactly 68 cycles per word.
- Two `galvo_go` 10 cycles apart: the second is served immediately after the first's `galvo_spi_done`; `overrun` stays 0. A third go while pending sets `overrun`=1.
- limH=0, limV=2, repeated go: `galvov` 1,2,0; `frame_done` pulses once, on the 0 wrap.
- `scan_restart` in the middle of a SHIFT:
  - Next cycle cs_n=1, sclk=0, position 0,0, `overrun` cleared.
  - Two full words follow: 0x0000 then 0x2000.
  - Then `galvo_spi_done` fires.
- `scan_en`=0 with go pulses: no position change, no SPI activity, `busy` stays 0. Async reset mid-word drives cs_n=1 immediately.
